// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: shared types and constants for the RV32M multiply/divide sequencer
package mdu_sequencer_pkg;
   typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mdu_op_type;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_type;
   localparam int MDU_ITERATIONS = 32;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's complement negate, used for operand magnitudes and result sign correction
module mdu_sign_fix #(parameter int W = 32) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] fixed
);
   assign fixed = negate ? -value : value;
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative 32-step shift-add multiply / restoring divide for RV32M in the execute stage
import mdu_sequencer_pkg::*;
module mdu_sequencer #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] left_operand,
   input  logic [WIDTH-1:0] right_operand,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             result_valid,
   output logic [WIDTH-1:0] result
);
   mdu_state_type state, state_nxt;
   mdu_op_type op_i, op_q;
   logic [5:0] cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod_fix;
   logic [WIDTH-1:0] opd, a_mag, b_mag, quo_fix, rem_fix, special_val, final_val;
   logic [WIDTH:0] sum, part, diff;
   logic neg_res, neg_a, sa, sb, is_div, div_zero, ovf, special, accept, finish;
   assign op_i = mdu_op_type'(op);
   assign is_div = op[2];
   assign sa = (op_i == MULH) || (op_i == MULHSU) || (is_div && !op[0]);
   assign sb = (op_i == MULH) || (is_div && !op[0]);
   mdu_sign_fix #(WIDTH) u_a_mag (.value(left_operand), .negate(sa && left_operand[WIDTH-1]), .fixed(a_mag));
   mdu_sign_fix #(WIDTH) u_b_mag (.value(right_operand), .negate(sb && right_operand[WIDTH-1]), .fixed(b_mag));
   // divide by zero and signed overflow bypass the loop with a preloaded result
   assign div_zero = is_div && (right_operand == '0);
   assign ovf = is_div && !op[0] && (left_operand == {1'b1, {(WIDTH-1){1'b0}}}) && (&right_operand);
   assign special = div_zero || ovf;
   assign special_val = div_zero ? (op[1] ? left_operand : '1) : (op[1] ? '0 : left_operand);
   assign accept = (state == IDLE) && start && !flush;
   assign finish = (state == BUSY) && (cnt == 6'd1) && !flush;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = IDLE;
      if (!flush)
         state_nxt = (state == IDLE) ? (start ? (special ? DONE : BUSY) : IDLE) :
                     (state == BUSY) ? ((cnt == 6'd1) ? DONE : BUSY) : IDLE;
   end
   always_comb begin
      stall = !rst && (accept || (state == BUSY));
      busy = state != IDLE;
   end
   // one iteration per cycle; the divide step carries the bit shifted out of the remainder
   always_comb begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
      part = acc[2*WIDTH-1:WIDTH-1];
      diff = part - {1'b0, opd};
      acc_nxt = op_q[2] ? (diff[WIDTH] ? {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                        : {sum, acc[WIDTH-1:1]};
   end
   mdu_sign_fix #(2*WIDTH) u_prod_fix (.value(acc_nxt), .negate(neg_res), .fixed(prod_fix));
   mdu_sign_fix #(WIDTH) u_quo_fix (.value(acc_nxt[WIDTH-1:0]), .negate(neg_res), .fixed(quo_fix));
   mdu_sign_fix #(WIDTH) u_rem_fix (.value(acc_nxt[2*WIDTH-1:WIDTH]), .negate(neg_a), .fixed(rem_fix));
   assign final_val = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q == MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         acc <= '0;
         opd <= '0;
         op_q <= MUL;
         neg_res <= 1'b0;
         neg_a <= 1'b0;
         result <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= state_nxt == DONE;
         if (accept) begin
            op_q <= op_i;
            opd <= is_div ? b_mag : a_mag;
            acc <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            cnt <= 6'(MDU_ITERATIONS);
            neg_res <= (sa && left_operand[WIDTH-1]) ^ (sb && right_operand[WIDTH-1]);
            neg_a <= sa && left_operand[WIDTH-1];
            if (special) result <= special_val;
         end else if (state == BUSY) begin
            acc <= acc_nxt;
            cnt <= cnt - 6'd1;
            if (finish) result <= final_val;
         end
      end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: randomized and directed checks of mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;
   logic clk = 0, rst = 1, start = 0, flush = 0;
   logic [2:0] op = 0;
   logic [31:0] left_operand = 0, right_operand = 0;
   logic stall, busy, result_valid;
   logic [31:0] result;
   int checks = 0, fails = 0;

   mdu_sequencer dut (.clk(clk), .rst(rst), .start(start), .op(op), .left_operand(left_operand),
      .right_operand(right_operand), .flush(flush), .stall(stall), .busy(busy),
      .result_valid(result_valid), .result(result));

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic ov;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (o)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ov ? 32'd0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // issue one op holding start until the result appears; cycle 0 is the issue cycle
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int valid_at, output logic [31:0] r);
      @(negedge clk);
      op = o; left_operand = a; right_operand = b; start = 1;
      stalls = 0; valid_at = -1; r = 'x;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (stall) stalls++;
         if (result_valid) begin valid_at = c; r = result; break; end
         @(negedge clk);
      end
      start = 0;
   endtask

   task automatic test_reset();
      start = 1; op = 3'd0; left_operand = 7; right_operand = 6;
      #12;
      checks++;
      if ({busy, stall, result_valid} !== 3'b000 || result !== 32'd0) begin
         fails++;
         $display("FAIL reset: busy/stall/valid=%b result=%h, want 000 / 00000000", {busy, stall, result_valid}, result);
      end
      start = 0;
      @(negedge clk); rst = 0;
   endtask

   task automatic test_directed();
      logic [2:0] ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] as [12] = '{7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               100, 100, 5, 5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs [12] = '{6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 2, 2, 7, 7, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex [12] = '{42, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               14, 2, 32'hFFFF_FFFF, 5, 32'h8000_0000, 0};
      int ex_t [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
      int stalls, vat;
      logic [31:0] r;
      for (int i = 0; i < 12; i++) begin
         run_op(ops[i], as[i], bs[i], stalls, vat, r);
         checks++;
         if (r !== ex[i] || stalls != ex_t[i] || vat != ex_t[i]) begin
            fails++;
            $display("FAIL directed[%0d] op=%0d: result=%h stalls=%0d valid_at=%0d, want %h %0d %0d",
                     i, ops[i], r, stalls, vat, ex[i], ex_t[i], ex_t[i]);
         end
         @(negedge clk); #1;
         checks++;
         if (result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pulse[%0d]: result_valid=%b busy=%b after DONE, want 0 0", i, result_valid, busy);
         end
      end
   endtask

   task automatic test_random();
      int stalls, vat, et;
      logic [2:0] o;
      logic [31:0] a, b, r, e;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         e = model(o, a, b);
         et = is_special(o, a, b) ? 1 : 33;
         run_op(o, a, b, stalls, vat, r);
         checks++;
         if (r !== e || stalls != et || vat != et) begin
            fails++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: result=%h stalls=%0d valid_at=%0d, want %h %0d %0d",
                     i, o, a, b, r, stalls, vat, e, et, et);
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] prev;
      int pulses;
      prev = result;
      @(negedge clk);
      op = 3'd0; left_operand = 11; right_operand = 13; start = 1;
      repeat (10) @(negedge clk);
      flush = 1;
      @(negedge clk);
      flush = 0; start = 0;
      #1;
      checks++;
      if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result !== prev) begin
         fails++;
         $display("FAIL flush_busy: stall=%b busy=%b valid=%b result=%h, want 0 0 0 %h", stall, busy, result_valid, result, prev);
      end
      pulses = 0;
      repeat (40) begin @(negedge clk); #1; if (result_valid) pulses++; end
      checks++;
      if (pulses != 0 || result !== prev) begin
         fails++;
         $display("FAIL flush_no_result: pulses=%0d result=%h, want 0 %h", pulses, result, prev);
      end
      @(negedge clk);
      start = 1; flush = 1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         fails++;
         $display("FAIL flush_start_stall: stall=%b, want 0", stall);
      end
      @(negedge clk);
      start = 0; flush = 0;
      #1;
      checks++;
      if (busy !== 1'b0 || result_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_start_idle: busy=%b valid=%b, want 0 0", busy, result_valid);
      end
   endtask

   task automatic test_async_reset();
      int stalls, vat;
      logic [31:0] r;
      @(negedge clk);
      op = 3'd0; left_operand = 5; right_operand = 9; start = 1;
      repeat (5) @(negedge clk);
      #2 rst = 1;
      #1;
      checks++;
      if ({busy, stall, result_valid} !== 3'b000 || result !== 32'd0) begin
         fails++;
         $display("FAIL async_reset: busy/stall/valid=%b result=%h, want 000 00000000", {busy, stall, result_valid}, result);
      end
      start = 0;
      @(negedge clk); rst = 0;
      run_op(3'd0, 3, 3, stalls, vat, r);
      checks++;
      if (r !== 32'd9 || stalls != 33 || vat != 33) begin
         fails++;
         $display("FAIL after_reset_mul: result=%h stalls=%0d valid_at=%0d, want 00000009 33 33", r, stalls, vat);
      end
   endtask

   task automatic test_back_to_back();
      int stalls, vat, t0;
      logic [31:0] r;
      run_op(3'd5, 1000, 9, stalls, vat, r);
      t0 = int'($time);
      checks++;
      if (r !== 32'd111 || vat != 33) begin
         fails++;
         $display("FAIL b2b_first: result=%h valid_at=%0d, want 0000006f 33", r, vat);
      end
      run_op(3'd7, 1000, 9, stalls, vat, r);
      checks++;
      if (r !== 32'd1 || int'($time) - t0 != 340 || stalls != 33) begin
         fails++;
         $display("FAIL b2b_second: result=%h interval=%0d stalls=%0d, want 00000001 340 33", r, int'($time) - t0, stalls);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the RV32M instructions in the execute stage. It accepts post-forwarding operands when an M-extension op is issued, stalls the pipeline while it runs a 32-step shift-add or restoring-division loop, and returns a single-cycle-valid result for the execute-stage result mux. The integer ALU is left free for all other instructions.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  execute stage holds a valid M-extension instruction.
- op  in  3  mdu_op_type: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 encoding 0..7).
- left_operand  in  32  rs1 value after forwarding mux.
- right_operand  in  32  rs2 value after forwarding mux.
- flush  in  1  kill the in-flight op (branch mispredict / exception).
- stall  out  1  hold IF/ID/EX and bubble EX/MEM.
- busy  out  1  state != IDLE.
- result_valid  out  1  result valid this cycle.
- result  out  32  final value, registered.

## Operation
- States: IDLE, BUSY, DONE (mdu_state_type).
- **IDLE:**
  - On start && !flush, latch op, the operand magnitudes, and the result sign.
  - Load a 6-bit counter with 32 and go to BUSY.
  - Special cases go straight to DONE with result preloaded:
    - DIV/DIVU with divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **Signedness:**
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - All others: unsigned.
  - Magnitude = two's complement negate if signed and negative.
- **BUSY:** one iteration per cycle; the counter decrements and the state moves to DONE when the counter reaches 0.
  - Multiply: 64-bit accumulator shift-add on the multiplier LSB.
  - Divide: restoring step on a 64-bit {remainder, quotient} register.
- **Sign fix:** applied on the BUSY→DONE transition, then written into the result register.
  - MUL → low 32 bits.
  - MULH/MULHSU/MULHU → high 32 bits of the sign-corrected 64-bit product.
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
- **DONE:** result_valid = 1, stall = 0, and the pipeline advances. start is ignored here, because the same instruction is still present. Next state is IDLE unconditionally.
- **Flush:**
  - In any state, flush returns the FSM to IDLE next cycle with no result_valid.
  - flush has priority over start in the same cycle.
  - result keeps its old value.
- **Reset:** state = IDLE, counter = 0, result = 0, result_valid = 0, busy = 0, and stall = 0 while rst is high.

## Timing
- stall = (state == IDLE && start && !flush) || state == BUSY. This is combinational, so stall rises in the issue cycle.
- Normal op: issue at cycle 0, BUSY in cycles 1..32, DONE in cycle 33. stall is high for 33 cycles (0..32), and result_valid is high in cycle 33 only.
- Special-case op: issue at cycle 0, DONE in cycle 1. stall is high in cycle 0 only.
- Back-to-back M ops: a new start is accepted in the cycle after DONE. The minimum issue interval is 34 cycles.
- result and result_valid are registered. The result register is written only when entering DONE.
- rst asserted mid-BUSY takes effect immediately, with no result produced.

## Structure
- The common package holds:
  - mdu_op_type, a 3-bit enum matching funct3;
  - mdu_state_type;
  - a localparam MDU_ITERATIONS = 32.
- control_type gains an MDUOp flag that drives start.
- This is a single module: FSM, counter, and the 64-bit shift datapath in one file. The optional sub-module mdu_sign_fix (combinational magnitude/negate helper) is used at both entry and exit.

## Test plan
- MUL with rs1 = 7, rs2 = 6: stall for 33 cycles, then result = 42 and result_valid pulses for 1 cycle in cycle 33.
- MULH with 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU with 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV with −7 / 2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). DIVU with 100 / 7 → 14. REMU with 100 / 7 → 2.
- Divide by zero and overflow, each completing with stall high for 1 cycle:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Flush in BUSY cycle 10: next cycle IDLE with stall = 0, no result_valid pulse, result unchanged. flush and start in the same IDLE cycle: stall = 0, state stays IDLE.
- Async rst asserted in BUSY cycle 5 between clock edges: busy, stall, and result_valid drop immediately. After release, a new MUL 3 × 3 → 9 with normal timing.
